// File: rtl/serdes_pkg.sv
// Shared serial-link definitions: default frame width and the receive FSM state encoding.
package serdes_pkg;

  localparam int FRAME_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/stp_out_buf.sv
// Single-entry holding register with valid/ready handshake; a word arriving while the
// entry is full and not being drained is dropped and flagged with a one-cycle overrun.
module stp_out_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             overrun
);

  logic accept;

  assign accept = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (accept) begin
          data      <= word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stp_reg.sv
// Serial-to-parallel receiver: start-triggered WIDTH-bit frame capture feeding a
// handshaked holding register, with registered done/overrun/abort status pulses.
module stp_reg
  import serdes_pkg::*;
#(
  parameter int WIDTH     = FRAME_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             done,
  output logic             overrun,
  output logic             abort
);

  localparam int CW = $clog2(WIDTH);

  rx_state_t      state, state_nx;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] sr, sr_shift;
  logic           frame_end, restart;

  always_comb begin
    if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], in};
    else           sr_shift = {in, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (frame_end && !start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame completion wins over a coincident start, which then opens the next frame.
  always_comb begin
    frame_end = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    restart   = (state == SHIFT) && start && !frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sr    <= '0;
      done  <= 1'b0;
      abort <= 1'b0;
    end else begin
      done  <= frame_end;
      abort <= restart;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (frame_end || restart) begin
        cnt <= '0;
        if (frame_end) sr <= sr_shift;
      end else begin
        cnt <= cnt + 1'b1;
        sr  <= sr_shift;
      end
    end
  end

  stp_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (frame_end),
    .word      (sr_shift),
    .out_ready (out_ready),
    .data      (data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_stp_reg.sv
// Directed bench for stp_reg: 32-bit MSB-first and 8-bit LSB-first instances, scoreboard of delivered words.
module tb_stp_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, in32, out_ready32;
  logic [31:0] data32;
  logic        out_valid32, done32, overrun32, abort32;
  logic        start8, in8, out_ready8;
  logic [7:0]  data8;
  logic        out_valid8, done8, overrun8, abort8;

  int tests = 0;
  int fails = 0;
  int abort_cnt = 0;
  int ovr_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  stp_reg #(.WIDTH(32), .MSB_FIRST(1'b1)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .in(in32), .out_ready(out_ready32),
    .data(data32), .out_valid(out_valid32), .done(done32), .overrun(overrun32), .abort(abort32)
  );

  stp_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in(in8), .out_ready(out_ready8),
    .data(data8), .out_valid(out_valid8), .done(done8), .overrun(overrun8), .abort(abort8)
  );

  always @(posedge clk) begin
    if (abort32)   abort_cnt <= abort_cnt + 1;
    if (overrun32) ovr_cnt   <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [63:0] got);
    logic [63:0] e;
    chk({tag, "_queued"}, 64'(exp_q.size() > 0), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk(tag, got, e);
  endtask

  task automatic start_pulse32();
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
  endtask

  // Sends a 32-bit word MSB first; chain raises start on the last bit for a zero-gap next frame.
  task automatic shift32(input logic [31:0] w, input bit chain);
    for (int i = 0; i < 32; i++) begin
      in32    = w[31-i];
      start32 = chain && (i == 31);
      tick();
    end
    start32 = 1'b0;
  endtask

  // Sends bit i of b as the i-th serial bit.
  task automatic frame8(input logic [7:0] b);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in8 = b[i];
      tick();
    end
  endtask

  initial begin
    int base_a, base_o;
    rst = 1'b1;
    start32 = 1'b0; in32 = 1'b0; out_ready32 = 1'b1;
    start8  = 1'b0; in8  = 1'b0; out_ready8  = 1'b1;
    tick(); tick(); tick();
    chk("rst_data32", data32, 0);
    chk("rst_valid32", out_valid32, 0);
    chk("rst_done32", done32, 0);
    chk("rst_overrun32", overrun32, 0);
    chk("rst_abort32", abort32, 0);
    chk("rst_data8", data8, 0);
    chk("rst_valid8", out_valid8, 0);
    rst = 1'b0;
    in32 = 1'b1;
    tick();

    // Loopback word, ready held high
    exp_q.push_back(64'hA5A50F0F);
    start_pulse32();
    shift32(32'hA5A50F0F, 1'b0);
    chk("loop_done", done32, 1);
    chk("loop_valid", out_valid32, 1);
    check_word("loop_data", data32);
    tick();
    chk("loop_done_pulse", done32, 0);
    chk("loop_valid_clear", out_valid32, 0);

    // Back-to-back frames, start on frame-end edge
    base_a = abort_cnt; base_o = ovr_cnt;
    exp_q.push_back(64'hDEADBEEF);
    exp_q.push_back(64'h12345678);
    start_pulse32();
    shift32(32'hDEADBEEF, 1'b1);
    chk("b2b_done1", done32, 1);
    check_word("b2b_data1", data32);
    shift32(32'h12345678, 1'b0);
    chk("b2b_done2", done32, 1);
    check_word("b2b_data2", data32);
    tick();
    chk("b2b_no_abort", abort_cnt, base_a);
    chk("b2b_no_overrun", ovr_cnt, base_o);

    // Overrun while consumer stalls
    out_ready32 = 1'b0;
    exp_q.push_back(64'h00000001);
    start_pulse32();
    shift32(32'h00000001, 1'b0);
    check_word("ovr_data1", data32);
    chk("ovr_valid1", out_valid32, 1);
    base_o = ovr_cnt;
    start_pulse32();
    shift32(32'hFFFFFFFF, 1'b0);
    chk("ovr_pulse", overrun32, 1);
    chk("ovr_done", done32, 1);
    chk("ovr_data_held", data32, 32'h00000001);
    tick();
    chk("ovr_pulse_end", overrun32, 0);
    chk("ovr_data_stable", data32, 32'h00000001);
    out_ready32 = 1'b1;
    tick();
    chk("ovr_valid_clear", out_valid32, 0);
    chk("ovr_once", ovr_cnt, base_o + 1);

    // Restart after 10 bits
    base_a = abort_cnt;
    start_pulse32();
    for (int i = 0; i < 10; i++) begin
      in32 = i[0];
      tick();
    end
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    chk("abort_pulse", abort32, 1);
    exp_q.push_back(64'hCAFEF00D);
    shift32(32'hCAFEF00D, 1'b0);
    check_word("abort_data", data32);
    out_ready32 = 1'b0;
    tick();
    chk("abort_once", abort_cnt, base_a + 1);
    chk("abort_valid_held", out_valid32, 1);

    // Reset at bit 20 of a frame
    base_a = abort_cnt;
    start_pulse32();
    for (int i = 0; i < 19; i++) begin
      in32 = 1'b1;
      tick();
    end
    rst = 1'b1;
    start32 = 1'b1;
    tick();
    rst = 1'b0;
    start32 = 1'b0;
    chk("midrst_data", data32, 0);
    chk("midrst_valid", out_valid32, 0);
    chk("midrst_done", done32, 0);
    chk("midrst_overrun", overrun32, 0);
    chk("midrst_abort", abort32, 0);
    out_ready32 = 1'b1;
    exp_q.push_back(64'h0F0F0F0F);
    start_pulse32();
    shift32(32'h0F0F0F0F, 1'b0);
    chk("postrst_done", done32, 1);
    check_word("postrst_data", data32);
    chk("postrst_no_abort", abort_cnt, base_a);

    // 8-bit, first received bit lands in data[0]
    exp_q.push_back(64'h81);
    frame8(8'b1000_0001);
    chk("w8_done1", done8, 1);
    check_word("w8_data1", data8);
    exp_q.push_back(64'h03);
    frame8(8'b0000_0011);
    chk("w8_done2", done8, 1);
    check_word("w8_data2", data8);
    chk("w8_no_abort", abort8, 0);
    chk("w8_no_overrun", overrun8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
